// File: rtl/mem_access_pkg.sv
// Shared encodings and sizing helpers for the memory-access stage.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    typedef enum logic {
        SZ_BYTE = 1'b0,
        SZ_WORD = 1'b1
    } size_t;

    localparam int DEF_DATA_W  = 16;
    localparam int LANES       = DEF_DATA_W / 8;
    localparam int LB          = $clog2(LANES);
    localparam int DEF_TIMEOUT = 15;

    // Number of low address bits that select a byte lane for a given width.
    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: picks the addressed byte lane and extends it,
// or passes a full word straight through.
module mem_load_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LBITS  = LB
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [LBITS-1:0]  i_lane,
    input  logic              i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_data
);
    localparam int LANES_L = DATA_W / 8;

    logic [7:0] w_lanes [LANES_L];
    logic [7:0] w_byte;

    genvar gi;
    generate
        for (gi = 0; gi < LANES_L; gi++) begin : g_lane
            assign w_lanes[gi] = i_rdata[gi*8 +: 8];
        end
    endgenerate

    assign w_byte = w_lanes[i_lane];

    // Word loads pass through; byte loads are sign- or zero-extended.
    always_comb begin
        o_data = i_rdata;
        if (size_t'(i_size) == SZ_BYTE) begin
            o_data = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives a req/gnt/rvalid bus, aligns load
// data, flags misaligned and timed-out accesses, and fills the WB register.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_ex_valid,
    input  logic                 i_ex_mem_rd,
    input  logic                 i_ex_mem_wr,
    input  logic                 i_ex_size,
    input  logic                 i_ex_signed,
    input  logic [DATA_W-1:0]    i_ex_alu_result,
    input  logic [DATA_W-1:0]    i_ex_store_data,
    output logic                 o_mem_busy,
    output logic                 o_bus_req,
    output logic                 o_bus_we,
    output logic [ADDR_W-1:0]    o_bus_addr,
    output logic [DATA_W-1:0]    o_bus_wdata,
    output logic [DATA_W/8-1:0]  o_bus_be,
    input  logic                 i_bus_gnt,
    input  logic                 i_bus_rvalid,
    input  logic [DATA_W-1:0]    i_bus_rdata,
    output logic                 o_wb_valid,
    output logic [DATA_W-1:0]    o_wb_mem_out,
    output logic [DATA_W-1:0]    o_wb_alu_result,
    output logic                 o_wb_fault
);
    localparam int LANES_L = DATA_W / 8;
    localparam int LB_L    = lane_bits(DATA_W);
    localparam int CNT_W   = $clog2(TIMEOUT + 1) + 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_bus_req, r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [LANES_L-1:0]  r_be;
    logic [LB_L-1:0]     r_lane;
    logic                r_size, r_signed;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_hold_data;
    logic                r_hold_fault;
    logic                r_wb_valid, r_wb_fault;
    logic [DATA_W-1:0]   r_wb_mem_out, r_wb_alu;

    logic [ADDR_W-1:0]   w_ex_addr;
    logic [LB_L-1:0]     w_lane;
    logic [LANES_L-1:0]  w_be_byte;
    logic                w_is_mem, w_misaligned, w_accept;
    logic                w_store_done, w_load_done, w_timeout, w_finish;
    logic [DATA_W-1:0]   w_aligned, w_fin_data;

    assign w_ex_addr    = i_ex_alu_result[ADDR_W-1:0];
    assign w_lane       = w_ex_addr[LB_L-1:0];
    assign w_is_mem     = i_ex_mem_rd | i_ex_mem_wr;
    assign w_misaligned = (size_t'(i_ex_size) == SZ_WORD) && (w_lane != '0);
    assign w_accept     = i_ex_valid && (r_state == ST_IDLE) && !i_stall;

    genvar gi;
    generate
        for (gi = 0; gi < LANES_L; gi++) begin : g_be
            assign w_be_byte[gi] = (w_lane == LB_L'(gi));
        end
    endgenerate

    mem_load_align #(.DATA_W(DATA_W), .LBITS(LB_L)) u_align (
        .i_rdata  (i_bus_rdata),
        .i_lane   (r_lane),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_aligned)
    );

    // Completion sources; rvalid only counts in RESP, so stray or
    // gnt-coincident responses are ignored.
    assign w_store_done = (r_state == ST_REQ) && i_bus_gnt && r_we;
    assign w_load_done  = (r_state == ST_RESP) && i_bus_rvalid;
    assign w_timeout    = (((r_state == ST_REQ) && !i_bus_gnt) ||
                           ((r_state == ST_RESP) && !i_bus_rvalid)) &&
                          (r_cnt >= CNT_W'(TIMEOUT - 1));
    assign w_finish     = w_store_done | w_load_done | w_timeout;
    assign w_fin_data   = w_load_done ? w_aligned : '0;

    // Bus FSM, timeout counter, hold buffer and WB pipeline register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bus_req    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_lane       <= '0;
            r_size       <= 1'b0;
            r_signed     <= 1'b0;
            r_alu        <= '0;
            r_hold_data  <= '0;
            r_hold_fault <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_fault   <= 1'b0;
            r_wb_mem_out <= '0;
            r_wb_alu     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_mem && !w_misaligned) begin
                        r_state   <= ST_REQ;
                        r_cnt     <= '0;
                        r_bus_req <= 1'b1;
                        r_we      <= i_ex_mem_wr;
                        r_addr    <= w_ex_addr & ~ADDR_W'(LANES_L - 1);
                        r_be      <= (size_t'(i_ex_size) == SZ_WORD) ? '1 : w_be_byte;
                        r_wdata   <= (size_t'(i_ex_size) == SZ_WORD) ? i_ex_store_data
                                     : {LANES_L{i_ex_store_data[7:0]}};
                        r_lane    <= w_lane;
                        r_size    <= i_ex_size;
                        r_signed  <= i_ex_signed;
                        r_alu     <= i_ex_alu_result;
                    end
                end
                ST_REQ: begin
                    if (i_bus_gnt) begin
                        r_bus_req <= 1'b0;
                        if (!r_we) begin
                            r_state <= ST_RESP;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (!i_bus_rvalid && !w_timeout) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_finish) begin
                if (i_stall) begin
                    r_hold_data  <= w_fin_data;
                    r_hold_fault <= w_timeout;
                    r_state      <= ST_HOLD;
                end else begin
                    r_wb_valid   <= 1'b1;
                    r_wb_fault   <= w_timeout;
                    r_wb_mem_out <= w_fin_data;
                    r_wb_alu     <= r_alu;
                    r_state      <= ST_IDLE;
                end
            end else if (!i_stall) begin
                if (r_state == ST_HOLD) begin
                    r_wb_valid   <= 1'b1;
                    r_wb_fault   <= r_hold_fault;
                    r_wb_mem_out <= r_hold_data;
                    r_wb_alu     <= r_alu;
                    r_state      <= ST_IDLE;
                end else if (w_accept && (!w_is_mem || w_misaligned)) begin
                    r_wb_valid   <= 1'b1;
                    r_wb_fault   <= w_is_mem;
                    r_wb_mem_out <= '0;
                    r_wb_alu     <= i_ex_alu_result;
                end else begin
                    r_wb_valid   <= 1'b0;
                end
            end
        end
    end

    assign o_mem_busy      = (r_state != ST_IDLE);
    assign o_bus_req       = r_bus_req;
    assign o_bus_we        = r_we;
    assign o_bus_addr      = r_addr;
    assign o_bus_wdata     = r_wdata;
    assign o_bus_be        = r_be;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_fault      = r_wb_fault;
    assign o_wb_mem_out    = r_wb_mem_out;
    assign o_wb_alu_result = r_wb_alu;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (16-bit, TIMEOUT=4).
module tb_mem_access_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall, i_ex_valid, i_ex_mem_rd, i_ex_mem_wr, i_ex_size, i_ex_signed;
    logic [15:0] i_ex_alu_result, i_ex_store_data;
    logic        o_mem_busy, o_bus_req, o_bus_we;
    logic [15:0] o_bus_addr, o_bus_wdata;
    logic [1:0]  o_bus_be;
    logic        i_bus_gnt, i_bus_rvalid;
    logic [15:0] i_bus_rdata;
    logic        o_wb_valid, o_wb_fault;
    logic [15:0] o_wb_mem_out, o_wb_alu_result;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_stall         (i_stall),
        .i_ex_valid      (i_ex_valid),
        .i_ex_mem_rd     (i_ex_mem_rd),
        .i_ex_mem_wr     (i_ex_mem_wr),
        .i_ex_size       (i_ex_size),
        .i_ex_signed     (i_ex_signed),
        .i_ex_alu_result (i_ex_alu_result),
        .i_ex_store_data (i_ex_store_data),
        .o_mem_busy      (o_mem_busy),
        .o_bus_req       (o_bus_req),
        .o_bus_we        (o_bus_we),
        .o_bus_addr      (o_bus_addr),
        .o_bus_wdata     (o_bus_wdata),
        .o_bus_be        (o_bus_be),
        .i_bus_gnt       (i_bus_gnt),
        .i_bus_rvalid    (i_bus_rvalid),
        .i_bus_rdata     (i_bus_rdata),
        .o_wb_valid      (o_wb_valid),
        .o_wb_mem_out    (o_wb_mem_out),
        .o_wb_alu_result (o_wb_alu_result),
        .o_wb_fault      (o_wb_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Present one instruction for exactly one accepting edge.
    task automatic issue(input logic rd, input logic wr, input logic sz, input logic sg,
                         input logic [15:0] alu, input logic [15:0] sdata);
        i_ex_valid = 1'b1; i_ex_mem_rd = rd; i_ex_mem_wr = wr;
        i_ex_size = sz; i_ex_signed = sg; i_ex_alu_result = alu; i_ex_store_data = sdata;
        tick();
        i_ex_valid = 1'b0; i_ex_mem_rd = 1'b0; i_ex_mem_wr = 1'b0;
    endtask

    // Load with immediate grant and rvalid one cycle later.
    task automatic do_load(input string tag, input logic sz, input logic sg, input logic [15:0] alu,
                           input logic [15:0] exp_addr, input logic [1:0] exp_be,
                           input logic [15:0] exp_data);
        issue(1'b1, 1'b0, sz, sg, alu, 16'h0000);
        check({tag, "_req"}, o_bus_req, 1);
        check({tag, "_addr"}, o_bus_addr, exp_addr);
        check({tag, "_be"}, o_bus_be, exp_be);
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        check({tag, "_req_drop"}, o_bus_req, 0);
        check({tag, "_busy_resp"}, o_mem_busy, 1);
        i_bus_rvalid = 1'b1; i_bus_rdata = 16'h80FF;
        tick();
        i_bus_rvalid = 1'b0;
        check({tag, "_wb_valid"}, o_wb_valid, 1);
        check({tag, "_wb_data"}, o_wb_mem_out, exp_data);
        check({tag, "_wb_alu"}, o_wb_alu_result, alu);
        check({tag, "_busy_done"}, o_mem_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_stall = 1'b0; i_ex_valid = 1'b0; i_ex_mem_rd = 1'b0;
        i_ex_mem_wr = 1'b0; i_ex_size = 1'b0; i_ex_signed = 1'b0;
        i_ex_alu_result = '0; i_ex_store_data = '0;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
        tick(); tick();
        check("rst_busy", o_mem_busy, 0);
        check("rst_req", o_bus_req, 0);
        check("rst_be", o_bus_be, 0);
        check("rst_addr", o_bus_addr, 0);
        check("rst_wb_valid", o_wb_valid, 0);
        check("rst_wb_fault", o_wb_fault, 0);
        i_rst_n = 1'b1;
        tick();

        // Passthrough
        issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);
        check("pt_wb_valid", o_wb_valid, 1);
        check("pt_wb_alu", o_wb_alu_result, 16'h1234);
        check("pt_wb_mem", o_wb_mem_out, 0);
        check("pt_busy", o_mem_busy, 0);
        tick();
        check("pt_valid_clear", o_wb_valid, 0);

        // Byte store with grant in the third request cycle
        issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h0013, 16'h00AB);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) i_bus_gnt = 1'b1;
            check($sformatf("st_req_c%0d", c), o_bus_req, 1);
            check($sformatf("st_we_c%0d", c), o_bus_we, 1);
            check($sformatf("st_addr_c%0d", c), o_bus_addr, 16'h0012);
            check($sformatf("st_be_c%0d", c), o_bus_be, 2'b10);
            check($sformatf("st_wdata_c%0d", c), o_bus_wdata, 16'hABAB);
            check($sformatf("st_busy_c%0d", c), o_mem_busy, 1);
            check($sformatf("st_nowb_c%0d", c), o_wb_valid, 0);
            tick();
        end
        i_bus_gnt = 1'b0;
        check("st_wb_valid", o_wb_valid, 1);
        check("st_wb_fault", o_wb_fault, 0);
        check("st_wb_mem", o_wb_mem_out, 0);
        check("st_req_off", o_bus_req, 0);
        check("st_busy_off", o_mem_busy, 0);

        // Loads
        do_load("ld_sb", 1'b0, 1'b1, 16'h0021, 16'h0020, 2'b10, 16'hFF80);
        do_load("ld_ub", 1'b0, 1'b0, 16'h0021, 16'h0020, 2'b10, 16'h0080);
        do_load("ld_w",  1'b1, 1'b0, 16'h0020, 16'h0020, 2'b11, 16'h80FF);

        // Misaligned word load
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0031, 16'h0000);
        check("mis_req", o_bus_req, 0);
        check("mis_wb_valid", o_wb_valid, 1);
        check("mis_wb_fault", o_wb_fault, 1);
        check("mis_busy", o_mem_busy, 0);
        tick();
        check("mis_req_after", o_bus_req, 0);

        // Timeout: no grant ever
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("to_req_c%0d", c), o_bus_req, 1);
            tick();
        end
        check("to_req_drop", o_bus_req, 0);
        check("to_wb_valid", o_wb_valid, 1);
        check("to_wb_fault", o_wb_fault, 1);
        check("to_busy", o_mem_busy, 0);
        i_bus_rvalid = 1'b1; i_bus_rdata = 16'h5555;
        tick();
        i_bus_rvalid = 1'b0;
        check("to_stray_valid", o_wb_valid, 0);
        check("to_stray_busy", o_mem_busy, 0);

        // Completion under stall parks in HOLD
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0AAA, 16'h0000);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000);
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        i_stall = 1'b1; i_bus_rvalid = 1'b1; i_bus_rdata = 16'h1357;
        tick();
        i_bus_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("hold_busy_c%0d", c), o_mem_busy, 1);
            check($sformatf("hold_wb_valid_c%0d", c), o_wb_valid, 0);
            check($sformatf("hold_wb_mem_c%0d", c), o_wb_mem_out, 0);
            check($sformatf("hold_wb_alu_c%0d", c), o_wb_alu_result, 16'h0AAA);
            tick();
        end
        i_stall = 1'b0;
        tick();
        check("hold_rel_valid", o_wb_valid, 1);
        check("hold_rel_mem", o_wb_mem_out, 16'h1357);
        check("hold_rel_alu", o_wb_alu_result, 16'h0050);
        check("hold_rel_busy", o_mem_busy, 0);
        tick();

        // Reset during RESP
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0060, 16'h0000);
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        check("rr_busy_before", o_mem_busy, 1);
        i_rst_n = 1'b0;
        #1;
        check("rr_busy", o_mem_busy, 0);
        check("rr_req", o_bus_req, 0);
        check("rr_addr", o_bus_addr, 0);
        check("rr_be", o_bus_be, 0);
        check("rr_wb_valid", o_wb_valid, 0);
        check("rr_wb_alu", o_wb_alu_result, 0);
        i_bus_rvalid = 1'b1; i_bus_rdata = 16'h80FF;
        tick();
        i_rst_n = 1'b1;
        tick();
        i_bus_rvalid = 1'b0;
        check("rr_no_wb", o_wb_valid, 0);
        check("rr_idle", o_mem_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage for the Curveball CPU, between execute and writeback. It takes the ALU result as address and the store data. It drives a request/grant/response memory bus with wait states, and supports byte and word accesses with sign or zero extension. It generates a busy back-pressure signal, flags misaligned and timed-out accesses, and registers the result into the writeback pipeline register under an external stall.

## Interface
- DATA_W, 16, data/ALU width; multiple of 8, ≥16
- ADDR_W, 16, bus byte-address width; ≤ DATA_W
- TIMEOUT, 15, max cycles in REQ+RESP before abort; ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  downstream freeze; WB registers hold
- ex_valid  in  1  instruction present from execute
- ex_mem_rd / ex_mem_wr  in  1  load / store (never both)
- ex_size  in  1  0=byte, 1=word
- ex_signed  in  1  sign-extend byte loads
- ex_alu_result  in  DATA_W  ALU result; low ADDR_W bits = byte address
- ex_store_data  in  DATA_W  store data
- mem_busy  out  1  stage cannot accept; execute must hold
- bus_req  out  1  request valid
- bus_we  out  1  write
- bus_addr  out  ADDR_W  lane-aligned address
- bus_wdata  out  DATA_W  write data
- bus_be  out  DATA_W/8  byte enables
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  DATA_W  read data
- wb_valid  out  1  WB register valid
- wb_mem_out  out  DATA_W  aligned/extended load data (0 for non-loads)
- wb_alu_result  out  DATA_W  ALU result passthrough
- wb_fault  out  1  misaligned or timeout

## Operation
- Little-endian; LB = log2(DATA_W/8) low address bits select the lane.
- Accept = ex_valid & ~mem_busy & ~stall.
- Non-memory op: WB registers load next edge.
- Misaligned word access (addr[LB-1:0]≠0): no bus activity; the next edge writes wb_valid=1, wb_fault=1.
- Memory op: registered into bus outputs, then IDLE→REQ.
- bus_addr = addr with low LB bits cleared.
- Byte access: bus_be one-hot at the lane; store data byte replicated on all lanes.
- Word access: bus_be all ones.
- FSM states:
  - IDLE: accepts new instructions.
  - REQ: bus_req=1 with all bus_* stable. On bus_gnt, a store completes and a load goes to RESP.
  - RESP: waits for bus_rvalid, then captures rdata through the load aligner.
  - HOLD: a completion that occurs while stall=1 is buffered here. When stall drops, the buffer goes to WB and the FSM returns to IDLE.
- Completion with stall=0 goes straight to WB and the FSM returns to IDLE.
- mem_busy = (state≠IDLE).
- Timeout counter: cleared on entry to REQ, increments each REQ/RESP cycle. If TIMEOUT cycles pass without completion: bus_req drops, then wb_fault=1, wb_valid=1 (via HOLD if stalled).
- bus_rvalid outside RESP is ignored, including a late response after an abort. bus_rvalid coinciding with bus_gnt is ignored.
- wb_valid is cleared on an edge with ~stall and nothing completing or accepted.

## Timing
- Reset: state IDLE, counter 0. All outputs 0: mem_busy, bus_*, wb_*.
- An asserted rst mid-transaction aborts immediately; no WB result.
- Latency: non-mem/fault 1 cycle.
- Store: bus_req in the cycle after accept; wb_valid on the edge after bus_gnt. Minimum 2 cycles.
- Load: bus_rvalid no earlier than the cycle after bus_gnt. wb_valid on the edge after bus_rvalid. Minimum 3 cycles.
- While stall=1, all wb_* hold their values and nothing is accepted.

## Structure
- Package mem_access_pkg holds:
  - state encoding;
  - size encoding;
  - LANES = DATA_W/8 and LB;
  - default TIMEOUT.
- Sub-module mem_load_align (combinational) does lane select plus sign/zero extension for bytes, and word passthrough.

## Test plan
- Passthrough: non-mem op, alu=0x1234 → next cycle wb_valid=1, wb_alu_result=0x1234, wb_mem_out=0, mem_busy=0.
- Byte store, addr 0x0013, data 0x00AB, gnt delayed 2 cycles → bus_addr=0x0012, be=2'b10, wdata=0xABAB held stable 3 cycles. wb_valid one edge after gnt; mem_busy high throughout.
- Loads returning rdata 0x80FF:
  - signed byte at 0x0021 → wb_mem_out 0xFF80;
  - unsigned byte at 0x0021 → 0x0080;
  - word at 0x0020 → 0x80FF.
- Misaligned word load at 0x0031 → bus_req never asserted; next cycle wb_valid=1, wb_fault=1.
- TIMEOUT=4, gnt never asserted → bus_req high 4 cycles then low, wb_fault=1. A subsequent stray rvalid is ignored.
- rvalid while stall=1 → state HOLD, wb_* unchanged. Stall drops → load data on WB next edge.
- Separately, rst low during RESP → all outputs 0 immediately and no WB result appears.
